mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-master arbiter for the shared data-memory port of the `mem` subsystem. It sits between the CPU load/store path (master 0) and a second requester such as a UART/DMA bridge (master 1), and drives the single `address_virtual`/`writeData`/`WE` port into the MMU. It sequences each access as a fixed-length transaction, captures `readData` into a per-master register, and returns a one-cycle acknowledge.

## Interface
- `WAIT_CYCLES`, default 1: cycles the slave port is held per transaction; minimum 1, and 0 is illegal.
- `ADDR_W`, default 16: address width.
- `DATA_W`, default 32: data width.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset is asynchronous and active-high.
- `m0_req`, `m1_req` in 1: request. The master holds it, together with its `we`/`addr`/`wdata`, stable until its `ack`.
- `m0_we`, `m1_we` in 1: 1 = write, 0 = read.
- `m0_addr`, `m1_addr` in `ADDR_W`: virtual address.
- `m0_wdata`, `m1_wdata` in `DATA_W`: write data.
- `m0_gnt`, `m1_gnt` out 1: high for every cycle that master owns the slave port.
- `m0_ack`, `m1_ack` out 1: one-cycle completion pulse.
- `m0_rdata`, `m1_rdata` out `DATA_W`: registered read data. Valid from `ack` onward and held until that master's next read completes.
- `mem_we` out 1: to the memory `WE` input.
- `mem_addr` out `ADDR_W`: to `address_virtual`.
- `mem_wdata` out `DATA_W`: to `writeData`.
- `mem_rdata` in `DATA_W`: from `readData` (combinational within the cycle).

## Operation
- **FSM states:** IDLE, BUSY, ACK.
- **IDLE:**
  - Stays in IDLE if no request is present.
  - Otherwise selects a winner, latches `owner`, loads `cnt = WAIT_CYCLES-1` and moves to BUSY.
- **BUSY:**
  - Drives `mem_addr`/`mem_wdata` from the owner's inputs and asserts the owner's `gnt`.
  - Decrements `cnt`; when `cnt==0`, moves to ACK.
  - `mem_we` = owner `we` only in the last BUSY cycle (`cnt==0`), so exactly one memory write edge per transaction.
  - On reads, the `mem_rdata` value present in the last BUSY cycle is registered into the owner's `rdata` at the BUSY→ACK edge.
- **ACK:** owner's `ack` = 1, `gnt` = 0, slave port idle; always returns to IDLE.
- **Idle slave port:** outside BUSY, `mem_we`=0 and `mem_addr`/`mem_wdata`=0. This prevents spurious UART accesses with side effects.
- **Arbitration:** defined by `Configuration`. `last` register records the most recent owner.
- **Master drops `req` during BUSY:** the transaction still completes, the write still occurs and `ack` is still issued. The master must tolerate this.
- **Master keeps `req` high after `ack`:** treated as a new request in the following IDLE cycle.
- **Request in ACK:** a request arriving while in ACK is not seen until IDLE.
- **Other master's signals during BUSY:** ignored; its `gnt`/`ack` stay 0.

## Timing
- **Reset values:**
  - All `gnt`, `ack`, `rdata` = 0.
  - `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - State IDLE, `cnt`=0, `last`=1, so master 0 wins the first tie.
- **Latency:** request seen high at edge E → BUSY cycles E..E+W-1 → `ack` in cycle E+W → IDLE at E+W+1.
- **Throughput:** back-to-back throughput is one transaction per W+2 cycles.
- **Reset mid-transaction:** immediate abort with no `ack` and no `rdata` update. If reset asserts before the last-BUSY edge, no write occurs.
- **Read side effects:** `mem_rdata` is sampled only at the final BUSY edge; earlier BUSY cycles have no effect on `rdata`.
- **Counter:** width `$clog2(WAIT_CYCLES+1)`, with no wrap because it is reloaded on each grant.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - On simultaneous requests in IDLE, grant the master that is not `last`.
  - A single requester always wins.
- `MEM_ARB_ROUND_ROBIN_EN` undefined:
  - Fixed priority, master 0 always wins ties.
  - Master 1 may starve under continuous master-0 traffic.
  - `last` is still updated but unused.

## Test plan
- **Reset:** assert `rst` mid-BUSY of a write (W=3, addr 0x0010, data 0xDEADBEEF) → `mem_we` never high, no `ack`, all outputs 0; a subsequent read of 0x0010 returns the old value.
- **Single write then read:** m0 write 0x0004←0x12345678, then read 0x0004 (W=1) → `mem_we` high for exactly 1 cycle, `m0_ack` at E+1, `m0_rdata`=0x12345678.
- **Tie with macro defined:** both request continuously (W=2) → grants alternate m0,m1,m0,m1, `ack` every 4 cycles.
- **Tie with macro undefined:** both request continuously → m0 granted every transaction, `m1_ack` never asserts while `m0_req` stays high.
- **Request drop and rdata hold:** m1 drops `req` mid-BUSY of a write → write occurs and `m1_ack` still pulses; `m1_rdata` from a prior read (0xA5A5A5A5) stays unchanged across intervening m0 transactions.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of the two requester ports and the shared memory
// port that mem_arbiter serves.
//   master modport : requester + memory side (drives req/we/addr/wdata and
//                    mem_rdata; observes gnt/ack/rdata and the memory port)
//   slave modport  : arbiter side (mem_arbiter uses this one)
// Signals: m{0,1}_req/we/addr/wdata, m{0,1}_gnt/ack/rdata,
//          mem_we/mem_addr/mem_wdata (arbiter -> MMU), mem_rdata (MMU -> arbiter).
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
);
  logic              m0_req,   m1_req;
  logic              m0_we,    m1_we;
  logic [ADDR_W-1:0] m0_addr,  m1_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata;
  logic              m0_gnt,   m1_gnt;
  logic              m0_ack,   m1_ack;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
    input  m0_gnt, m1_gnt, m0_ack, m1_ack, m0_rdata, m1_rdata,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
    output m0_gnt, m1_gnt, m0_ack, m1_ack, m0_rdata, m1_rdata,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master arbiter for the shared data-memory port.
// Each access is a fixed transaction: IDLE -> BUSY (WAIT_CYCLES cycles) -> ACK.
// The memory port is driven only during BUSY; mem_we is raised only in the
// last BUSY cycle, and read data is captured at the BUSY->ACK edge.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - mem_arbiter_if.slave (requesters m0/m1 and the memory port)
// Parameters: WAIT_CYCLES (>=1, 0 is illegal), ADDR_W, DATA_W.
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN for round-robin tie
// breaking; otherwise master 0 has fixed priority.
module mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 32
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t            state, state_nxt;
  logic              owner, owner_nxt;
  logic              last,  last_nxt;
  logic [CNT_W-1:0]  cnt,   cnt_nxt;
  logic              win;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              cap0, cap1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      owner        <= 1'b0;
      last         <= 1'b1;
      cnt          <= '0;
      bus.m0_rdata <= '0;
      bus.m1_rdata <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
      if (cap0) bus.m0_rdata <= bus.mem_rdata;
      if (cap1) bus.m1_rdata <= bus.mem_rdata;
    end
  end

  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    last_nxt      = last;
    cnt_nxt       = cnt;
    win           = 1'b0;
    cap0          = 1'b0;
    cap1          = 1'b0;
    bus.m0_gnt    = 1'b0;
    bus.m1_gnt    = 1'b0;
    bus.m0_ack    = 1'b0;
    bus.m1_ack    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;

    sel_we    = owner ? bus.m1_we    : bus.m0_we;
    sel_addr  = owner ? bus.m1_addr  : bus.m0_addr;
    sel_wdata = owner ? bus.m1_wdata : bus.m0_wdata;

    case (state)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
          // Tie goes to whichever master did not own the port last.
          win = (bus.m0_req && bus.m1_req) ? ~last : bus.m1_req;
`else
          win = ~bus.m0_req;
`endif
          owner_nxt = win;
          last_nxt  = win;
          cnt_nxt   = CNT_W'(WAIT_CYCLES - 1);
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        bus.m0_gnt    = ~owner;
        bus.m1_gnt    = owner;
        bus.mem_addr  = sel_addr;
        bus.mem_wdata = sel_wdata;
        if (cnt == '0) begin
          // Single write strobe and read capture, both on the final BUSY cycle.
          bus.mem_we = sel_we;
          cap0       = ~sel_we & ~owner;
          cap1       = ~sel_we & owner;
          state_nxt  = ACK;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ACK: begin
        bus.m0_ack = ~owner;
        bus.m1_ack = owner;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with
// WAIT_CYCLES=2 and a simple memory model behind the shared port.
// Outputs are sampled on the falling clock edge. Build with or without
// MEM_ARB_ROUND_ROBIN_EN; the tie expectations follow the macro.
module tb_mem_arbiter;

  localparam int W = 2;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  mem_arbiter #(.WAIT_CYCLES(W), .ADDR_W(16), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [0:65535];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
  assign bus.mem_rdata = mem[bus.mem_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [4:0] ctl();
    return {bus.m0_gnt, bus.m1_gnt, bus.m0_ack, bus.m1_ack, bus.mem_we};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int m, input logic rq, input logic we,
                       input logic [15:0] a, input logic [31:0] wd);
    if (m == 0) begin
      bus.m0_req = rq; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = wd;
    end else begin
      bus.m1_req = rq; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = wd;
    end
  endtask

  // One complete transaction from one master; call at a falling edge.
  task automatic xact(input int m, input logic we, input logic [15:0] a,
                      input logic [31:0] wd, input logic [31:0] exp_rd);
    drive(m, 1'b1, we, a, wd);
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      chk("busy ctl", ctl(), {m == 0, m == 1, 1'b0, 1'b0, we && (k == W - 1)});
      chk("busy addr", bus.mem_addr, a);
      chk("busy wdata", bus.mem_wdata, wd);
    end
    @(negedge clk);
    chk("ack ctl", ctl(), {1'b0, 1'b0, m == 0, m == 1, 1'b0});
    chk("ack port idle", {bus.mem_addr, bus.mem_wdata}, '0);
    if (!we) chk("rdata", (m == 1) ? bus.m1_rdata : bus.m0_rdata, exp_rd);
    drive(m, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("idle ctl", ctl(), '0);
  endtask

  initial begin
    int t, p, own;
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);

    // Reset values
    @(negedge clk);
    chk("reset ctl", ctl(), '0);
    chk("reset port", {bus.mem_addr, bus.mem_wdata}, '0);
    chk("reset rdata", {bus.m0_rdata, bus.m1_rdata}, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle after reset", ctl(), '0);

    // Seed 0x0010, load m1_rdata so the reset clear is observable
    xact(0, 1'b1, 16'h0010, 32'h11112222, '0);
    xact(1, 1'b0, 16'h0010, '0, 32'h11112222);

    // Reset in the first BUSY cycle of a write: no write, no ack
    drive(0, 1'b1, 1'b1, 16'h0010, 32'hDEADBEEF);
    @(negedge clk);
    chk("abort busy ctl", ctl(), 5'b10000);
    #2 rst = 1'b1;
    #1;
    chk("abort rst ctl", ctl(), '0);
    chk("abort rst port", {bus.mem_addr, bus.mem_wdata}, '0);
    chk("abort rst rdata", {bus.m0_rdata, bus.m1_rdata}, '0);
    drive(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("abort no ack", ctl(), '0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort idle", ctl(), '0);
    xact(0, 1'b0, 16'h0010, '0, 32'h11112222);

    // Single write then read
    xact(0, 1'b1, 16'h0004, 32'h12345678, '0);
    xact(0, 1'b0, 16'h0004, '0, 32'h12345678);

    // m1 drops req mid-BUSY of a write; m1_rdata held across m0 traffic
    xact(0, 1'b1, 16'h0020, 32'hA5A5A5A5, '0);
    xact(1, 1'b0, 16'h0020, '0, 32'hA5A5A5A5);
    drive(1, 1'b1, 1'b1, 16'h0030, 32'h0BADF00D);
    @(negedge clk);
    chk("drop busy0 ctl", ctl(), 5'b01000);
    drive(1, 1'b0, 1'b1, 16'h0030, 32'h0BADF00D);
    @(negedge clk);
    chk("drop busy1 ctl", ctl(), 5'b01001);
    chk("drop busy1 addr", bus.mem_addr, 16'h0030);
    chk("drop busy1 wdata", bus.mem_wdata, 32'h0BADF00D);
    @(negedge clk);
    chk("drop ack ctl", ctl(), 5'b00010);
    drive(1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("drop idle ctl", ctl(), '0);
    xact(0, 1'b0, 16'h0030, '0, 32'h0BADF00D);
    xact(0, 1'b1, 16'h0024, 32'h5555AAAA, '0);
    xact(0, 1'b0, 16'h0024, '0, 32'h5555AAAA);
    chk("m1 rdata hold", bus.m1_rdata, 32'hA5A5A5A5);

    // Continuous tie from reset (last=1, so m0 takes the first grant)
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1'b1, 1'b0, 16'h0004, '0);
    drive(1, 1'b1, 1'b0, 16'h0020, '0);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      t   = c / 4;
      p   = c % 4;
      own = RR ? (t % 2) : 0;
      if (p < 2) begin
        chk("tie busy ctl", ctl(), {own == 0, own == 1, 1'b0, 1'b0, 1'b0});
        chk("tie busy addr", bus.mem_addr, (own == 1) ? 16'h0020 : 16'h0004);
      end else if (p == 2) begin
        chk("tie ack ctl", ctl(), {1'b0, 1'b0, own == 0, own == 1, 1'b0});
        chk("tie rdata", (own == 1) ? bus.m1_rdata : bus.m0_rdata,
            (own == 1) ? 32'hA5A5A5A5 : 32'h12345678);
      end else begin
        chk("tie idle ctl", ctl(), '0);
      end
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("final idle", ctl(), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
